// File: rtl/seg_pkg.sv
// Shared encodings for the 4-digit 7-segment scan controller:
// anode patterns, scan FSM states and per-slot digit selection helpers.
package seg_pkg;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] ANODE_D1  = 4'b0111;
  localparam logic [3:0] ANODE_D2  = 4'b1011;
  localparam logic [3:0] ANODE_D3  = 4'b1101;
  localparam logic [3:0] ANODE_D4  = 4'b1110;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  typedef logic [1:0] slot_t;

  function automatic logic [3:0] slot_anode(input slot_t s);
    logic [3:0] a;
    case (s)
      2'd0:    a = ANODE_D1;
      2'd1:    a = ANODE_D2;
      2'd2:    a = ANODE_D3;
      default: a = ANODE_D4;
    endcase
    return a;
  endfunction

  function automatic logic [3:0] slot_nibble(input logic [15:0] v, input slot_t s);
    logic [3:0] d;
    case (s)
      2'd0:    d = v[3:0];
      2'd1:    d = v[7:4];
      2'd2:    d = v[11:8];
      default: d = v[15:12];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable up-counter with a terminal-count flag against a runtime limit.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan scheduler: blank gap + ON slot per digit, with a
// single-entry pending buffer committed only at the end of each frame.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  digit_en,
  output logic [3:0]  anode,
  output logic [3:0]  one_digit,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] ON_LIM    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES - 1);

  state_t      state, nxt_state;
  slot_t       slot, nxt_slot;
  logic [15:0] pending, shown, nxt_shown;
  logic        pend_full, nxt_full;
  logic        accept, frame_end, commit;
  logic        tc;
  logic [CNT_W-1:0] limit;

  assign limit = (state == ST_BLANK) ? BLANK_LIM : ON_LIM;

  seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .ld     (tc),
    .ld_val ('0),
    .limit  (limit),
    .tc     (tc)
  );

  always_comb begin
    nxt_state = state;
    nxt_slot  = slot;
    frame_end = 1'b0;
    if (tc) begin
      if (state == ST_BLANK) begin
        nxt_state = ST_SHOW;
      end else begin
        nxt_state = ST_BLANK;
        nxt_slot  = slot_t'(slot + 2'd1);
        frame_end = (slot == 2'd3);
      end
    end
    // Commit only ever happens with ready low, so it can never collide with an accept.
    commit    = frame_end && pend_full;
    accept    = load_valid && load_ready;
    nxt_shown = commit ? pending : shown;
    nxt_full  = pend_full;
    if (commit) nxt_full = 1'b0;
    if (accept) nxt_full = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BLANK;
      slot       <= '0;
      pending    <= '0;
      shown      <= '0;
      pend_full  <= 1'b0;
      load_ready <= 1'b1;
      frame_done <= 1'b0;
      anode      <= ANODE_OFF;
      one_digit  <= '0;
    end else begin
      state      <= nxt_state;
      slot       <= nxt_slot;
      if (accept) pending <= load_data;
      shown      <= nxt_shown;
      pend_full  <= nxt_full;
      load_ready <= ~nxt_full;
      frame_done <= frame_end;
      // Outputs are computed from next-state values so they line up with the registered state.
      anode      <= (nxt_state == ST_SHOW && digit_en[nxt_slot]) ? slot_anode(nxt_slot) : ANODE_OFF;
      one_digit  <= slot_nibble(nxt_shown, nxt_slot);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with short slot timing (frame = 24 clocks).
module tb_seg_scan_ctrl;

  localparam int ON    = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = ON + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  anode;
  logic [3:0]  one_digit;
  logic        frame_done;

  seg_scan_ctrl #(.ON_CYCLES(ON), .BLANK_CYCLES(BLANK), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .digit_en  (digit_en),
    .anode     (anode),
    .one_digit (one_digit),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: edges since reset release, pending buffer, committed value.
  int          n;
  logic        m_full;
  logic [15:0] m_pend;
  logic [15:0] m_shown;
  logic [3:0]  m_en;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic        ready;
    logic        fd;
  } vec_t;

  vec_t tv[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_anode();
    int pos, s;
    logic [3:0] bit1;
    pos = n % FRAME;
    s = pos / SLOT;
    bit1 = 4'b1000 >> s;
    if ((pos % SLOT) >= BLANK && m_en[s]) return 4'hF ^ bit1;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_digit();
    logic [15:0] t;
    t = m_shown >> (4 * ((n % FRAME) / SLOT));
    return t[3:0];
  endfunction

  task automatic model_reset();
    n = 0;
    m_full = 1'b0;
    m_pend = '0;
    m_shown = '0;
    m_en = 4'hF;
  endtask

  task automatic check_model();
    chk("anode", {28'd0, anode}, {28'd0, exp_anode()});
    chk("one_digit", {28'd0, one_digit}, {28'd0, exp_digit()});
    chk("load_ready", {31'd0, load_ready}, {31'd0, ~m_full});
    chk("frame_done", {31'd0, frame_done}, {31'd0, (n > 0) && (n % FRAME == 0)});
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic [3:0] en);
    logic rdy;
    load_valid = v;
    load_data  = d;
    digit_en   = en;
    @(posedge clk);
    #1;
    n++;
    m_en = en;
    rdy = ~m_full;
    if ((n % FRAME == 0) && m_full) begin
      m_shown = m_pend;
      m_full  = 1'b0;
    end
    if (v && rdy) begin
      m_pend = d;
      m_full = 1'b1;
    end
    check_model();
  endtask

  task automatic idle_to(input int target, input logic [3:0] en);
    while (n < target) step(1'b0, 16'h0, en);
  endtask

  initial begin
    tv[0]  = '{0, 16'h0000, 4'hF, 4'hF, 4'h0, 1, 0};
    tv[1]  = '{0, 16'h0000, 4'hF, 4'h7, 4'h0, 1, 0};
    tv[2]  = '{1, 16'h1234, 4'hF, 4'h7, 4'h0, 0, 0};
    tv[3]  = '{0, 16'h0000, 4'hF, 4'h7, 4'h0, 0, 0};
    tv[4]  = '{0, 16'h0000, 4'hF, 4'h7, 4'h0, 0, 0};
    tv[5]  = '{0, 16'h0000, 4'hF, 4'hF, 4'h0, 0, 0};
    tv[6]  = '{0, 16'h0000, 4'hF, 4'hF, 4'h0, 0, 0};
    tv[7]  = '{0, 16'h0000, 4'hF, 4'hB, 4'h0, 0, 0};
    tv[8]  = '{0, 16'h0000, 4'hF, 4'hB, 4'h0, 0, 0};
    tv[9]  = '{0, 16'h0000, 4'hF, 4'hB, 4'h0, 0, 0};
    tv[10] = '{0, 16'h0000, 4'hF, 4'hB, 4'h0, 0, 0};
    tv[11] = '{0, 16'h0000, 4'hF, 4'hF, 4'h0, 0, 0};
    tv[12] = '{0, 16'h0000, 4'hF, 4'hF, 4'h0, 0, 0};
    tv[13] = '{0, 16'h0000, 4'hF, 4'hD, 4'h0, 0, 0};
    tv[14] = '{0, 16'h0000, 4'hF, 4'hD, 4'h0, 0, 0};
    tv[15] = '{0, 16'h0000, 4'hF, 4'hD, 4'h0, 0, 0};
    tv[16] = '{0, 16'h0000, 4'hF, 4'hD, 4'h0, 0, 0};
    tv[17] = '{0, 16'h0000, 4'hF, 4'hF, 4'h0, 0, 0};
    tv[18] = '{0, 16'h0000, 4'hF, 4'hF, 4'h0, 0, 0};
    tv[19] = '{0, 16'h0000, 4'hF, 4'hE, 4'h0, 0, 0};
    tv[20] = '{0, 16'h0000, 4'hF, 4'hE, 4'h0, 0, 0};
    tv[21] = '{0, 16'h0000, 4'hF, 4'hE, 4'h0, 0, 0};
    tv[22] = '{0, 16'h0000, 4'hF, 4'hE, 4'h0, 0, 0};
    tv[23] = '{0, 16'h0000, 4'hF, 4'hF, 4'h4, 1, 1};
    tv[24] = '{0, 16'h0000, 4'hF, 4'hF, 4'h4, 1, 0};

    model_reset();
    #23 reset_n = 1'b1;
    #1;
    chk("rst_anode", {28'd0, anode}, 32'hF);
    chk("rst_digit", {28'd0, one_digit}, 32'h0);
    chk("rst_ready", {31'd0, load_ready}, 32'h1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'h0);

    // First frame plus commit of 1234, against literal expectations.
    for (int unsigned i = 0; i < 25; i++) begin
      step(tv[i].valid, tv[i].data, tv[i].en);
      chk("tv_anode", {28'd0, anode}, {28'd0, tv[i].anode});
      chk("tv_digit", {28'd0, one_digit}, {28'd0, tv[i].digit});
      chk("tv_ready", {31'd0, load_ready}, {31'd0, tv[i].ready});
      chk("tv_fd", {31'd0, frame_done}, {31'd0, tv[i].fd});
    end

    // Frame 2 shows 1234; load ABCD, then 5678 offered while ready is low.
    step(1'b0, 16'h0, 4'hF);
    chk("f2_slot0", {anode, one_digit}, {24'd0, 4'h7, 4'h4});
    step(1'b1, 16'hABCD, 4'hF);
    chk("abcd_accept_ready", {31'd0, load_ready}, 32'h0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 16'h5678, 4'hF);
    idle_to(32, 4'hF);
    chk("f2_slot1", {anode, one_digit}, {24'd0, 4'hB, 4'h3});
    idle_to(38, 4'hF);
    chk("f2_slot2", {anode, one_digit}, {24'd0, 4'hD, 4'h2});
    idle_to(44, 4'hF);
    chk("f2_slot3", {anode, one_digit}, {24'd0, 4'hE, 4'h1});
    idle_to(50, 4'hF);
    chk("f3_abcd_not_5678", {anode, one_digit}, {24'd0, 4'h7, 4'hD});

    // Load on the commit edge with pending empty: visible only two frames later.
    idle_to(71, 4'hF);
    step(1'b1, 16'h9999, 4'hF);
    chk("commit_edge_fd", {31'd0, frame_done}, 32'h1);
    chk("commit_edge_ready", {31'd0, load_ready}, 32'h0);
    idle_to(74, 4'hF);
    chk("f4_still_abcd", {28'd0, one_digit}, 32'hD);
    idle_to(96, 4'hF);
    chk("f4_fd", {31'd0, frame_done}, 32'h1);
    idle_to(98, 4'hF);
    chk("f5_9999", {28'd0, one_digit}, 32'h9);

    // Disabled digits keep their slot time with anodes off.
    idle_to(104, 4'b0101);
    chk("en_slot1_off", {28'd0, anode}, 32'hF);
    idle_to(110, 4'b0101);
    chk("en_slot2_on", {28'd0, anode}, 32'hD);
    idle_to(116, 4'b0101);
    chk("en_slot3_off", {28'd0, anode}, 32'hF);
    idle_to(120, 4'b0101);
    chk("en_frame_len", {31'd0, frame_done}, 32'h1);

    // Asynchronous reset mid-SHOW of slot 2 with a load pending.
    step(1'b1, 16'h4321, 4'hF);
    idle_to(135, 4'hF);
    chk("pre_rst_show", {anode, one_digit}, {24'd0, 4'hD, 4'h9});
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_anode", {28'd0, anode}, 32'hF);
    chk("mid_rst_digit", {28'd0, one_digit}, 32'h0);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'h1);
    #3 reset_n = 1'b1;
    model_reset();
    check_model();
    idle_to(30, 4'hF);
    chk("post_rst_shown0", {28'd0, one_digit}, 32'h0);

    // Randomized traffic against the reference model.
    for (int unsigned i = 0; i < 600; i++) begin
      logic v;
      logic [3:0] en;
      v = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : m_en;
      step(v, 16'($urandom), en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
